// File: rtl/tilemap_pkg.sv
// Shared types and built-in ROM contents for the tilemap pixel pipeline.
// Pattern and palette contents are fixed functions so the ROMs infer without init files.
package tilemap_pkg;

  localparam int unsigned LATENCY  = 4;
  localparam int unsigned ChanW    = 4;
  localparam int unsigned MapAddrW = 12;
  localparam int unsigned PatAddrW = 14;

  typedef logic [MapAddrW-1:0] map_addr_t;
  typedef logic [PatAddrW-1:0] pat_addr_t;

  typedef struct packed {
    logic [ChanW-1:0] red;
    logic [ChanW-1:0] green;
    logic [ChanW-1:0] blue;
  } rgb_t;

  // Pattern ROM: diagonal stripes whose phase depends on the tile index.
  function automatic int unsigned pattern_cidx(input int unsigned tile, input int unsigned py,
                                               input int unsigned px);
    return (tile * 3 + px + py / 2) % 4;
  endfunction

  // Palette ROM: four banks of four colours, bank chosen by the tile index MSBs.
  function automatic rgb_t palette_rgb(input logic [3:0] addr);
    rgb_t c;
    c = '0;
    case (addr)
      4'h0: c = 12'h000;
      4'h1: c = 12'h0F0;
      4'h2: c = 12'h00F;
      4'h3: c = 12'hF00;
      4'h4: c = 12'h111;
      4'h5: c = 12'h2A5;
      4'h6: c = 12'h5C3;
      4'h7: c = 12'hFF0;
      4'h8: c = 12'h888;
      4'h9: c = 12'h0FF;
      4'hA: c = 12'hF0F;
      4'hB: c = 12'h7E1;
      4'hC: c = 12'h123;
      4'hD: c = 12'h456;
      4'hE: c = 12'h9AB;
      4'hF: c = 12'hFFF;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tilemap_ram.sv
// 1W/1R synchronous RAM holding the tile map; read-first on same-address collision.
module tilemap_ram #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Both updates are non-blocking, so a colliding read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tilemap_pixel_pipe.sv
// Four-stage tilemap renderer: scroll, tile-map lookup, pattern lookup, palette lookup.
// Scroll values are double-buffered and only go live at frame boundaries.
module tilemap_pixel_pipe
  import tilemap_pkg::*;
#(
  parameter int unsigned TILE_LOG2     = 3,
  parameter int unsigned MAP_COLS_LOG2 = 6,
  parameter int unsigned MAP_ROWS_LOG2 = 6,
  parameter int unsigned TILE_IDX_W    = 8,
  parameter int unsigned CIDX_W        = 2,
  parameter int unsigned CHAN_W        = 4,
  parameter int unsigned COL_W         = 10,
  parameter int unsigned ROW_W         = 9
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pix_valid,
  input  logic                                   pix_active,
  input  logic [COL_W-1:0]                       pix_col,
  input  logic [ROW_W-1:0]                       pix_row,
  input  logic                                   frame_start,
  input  logic                                   map_we,
  input  logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] map_waddr,
  input  logic [TILE_IDX_W-1:0]                  map_wdata,
  input  logic                                   scroll_we,
  input  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]     scroll_x_in,
  input  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]     scroll_y_in,
  output logic                                   out_valid,
  output logic [COL_W-1:0]                       out_col,
  output logic [ROW_W-1:0]                       out_row,
  output logic [CHAN_W-1:0]                      red,
  output logic [CHAN_W-1:0]                      green,
  output logic [CHAN_W-1:0]                      blue
);

  localparam int unsigned MxW   = MAP_COLS_LOG2 + TILE_LOG2;
  localparam int unsigned MyW   = MAP_ROWS_LOG2 + TILE_LOG2;
  localparam int unsigned MapAW = MAP_ROWS_LOG2 + MAP_COLS_LOG2;

  logic [MxW-1:0] sx_shadow_q, sx_shadow_d, sx_live_q, mx_d;
  logic [MyW-1:0] sy_shadow_q, sy_shadow_d, sy_live_q, my_d;

  always_comb begin
    sx_shadow_d = sx_shadow_q;
    sy_shadow_d = sy_shadow_q;
    if (scroll_we) begin
      sx_shadow_d = scroll_x_in;
      sy_shadow_d = scroll_y_in;
    end
    // Map wrap-around is plain truncation to the map's pixel extent.
    mx_d = MxW'(pix_col) + sx_live_q;
    my_d = MyW'(pix_row) + sy_live_q;
  end

  // Live copy follows the shadow's next value so a same-cycle load also goes live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_shadow_q <= '0;
      sy_shadow_q <= '0;
      sx_live_q   <= '0;
      sy_live_q   <= '0;
    end else begin
      sx_shadow_q <= sx_shadow_d;
      sy_shadow_q <= sy_shadow_d;
      if (frame_start) begin
        sx_live_q <= sx_shadow_d;
        sy_live_q <= sy_shadow_d;
      end
    end
  end

  // Stage 1: scrolled map coordinates
  logic             s1_valid_q, s1_active_q;
  logic [COL_W-1:0] s1_col_q;
  logic [ROW_W-1:0] s1_row_q;
  logic [MxW-1:0]   s1_mx_q;
  logic [MyW-1:0]   s1_my_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_active_q <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      s1_mx_q     <= '0;
      s1_my_q     <= '0;
    end else begin
      s1_valid_q  <= pix_valid;
      s1_active_q <= pix_active;
      s1_col_q    <= pix_col;
      s1_row_q    <= pix_row;
      s1_mx_q     <= mx_d;
      s1_my_q     <= my_d;
    end
  end

  // Stage 2: tile map read
  logic [MapAW-1:0]      map_raddr;
  logic [TILE_IDX_W-1:0] tile_idx;

  assign map_raddr = {s1_my_q[MyW-1 -: MAP_ROWS_LOG2], s1_mx_q[MxW-1 -: MAP_COLS_LOG2]};

  tilemap_ram #(
    .AddrW(MapAW),
    .DataW(TILE_IDX_W)
  ) u_map (
    .clk_i  (clk),
    .we_i   (map_we),
    .waddr_i(map_waddr),
    .wdata_i(map_wdata),
    .raddr_i(map_raddr),
    .rdata_o(tile_idx)
  );

  logic                 s2_valid_q, s2_active_q;
  logic [COL_W-1:0]     s2_col_q;
  logic [ROW_W-1:0]     s2_row_q;
  logic [TILE_LOG2-1:0] s2_px_q, s2_py_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_active_q <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
      s2_px_q     <= '0;
      s2_py_q     <= '0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      s2_active_q <= s1_active_q;
      s2_col_q    <= s1_col_q;
      s2_row_q    <= s1_row_q;
      s2_px_q     <= s1_mx_q[TILE_LOG2-1:0];
      s2_py_q     <= s1_my_q[TILE_LOG2-1:0];
    end
  end

  // Stage 3: pattern ROM read
  logic [CIDX_W-1:0] cidx_d;

  always_comb begin
    cidx_d = CIDX_W'(pattern_cidx(32'(tile_idx), 32'(s2_py_q), 32'(s2_px_q)));
  end

  logic              s3_valid_q, s3_active_q;
  logic [COL_W-1:0]  s3_col_q;
  logic [ROW_W-1:0]  s3_row_q;
  logic [1:0]        s3_bank_q;
  logic [CIDX_W-1:0] s3_cidx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q  <= 1'b0;
      s3_active_q <= 1'b0;
      s3_col_q    <= '0;
      s3_row_q    <= '0;
      s3_bank_q   <= '0;
      s3_cidx_q   <= '0;
    end else begin
      s3_valid_q  <= s2_valid_q;
      s3_active_q <= s2_active_q;
      s3_col_q    <= s2_col_q;
      s3_row_q    <= s2_row_q;
      s3_bank_q   <= tile_idx[TILE_IDX_W-1 -: 2];
      s3_cidx_q   <= cidx_d;
    end
  end

  // Stage 4: palette ROM read; blanking forces black
  rgb_t pal;

  always_comb begin
    pal = palette_rgb(4'({s3_bank_q, s3_cidx_q}));
  end

  logic              out_valid_q;
  logic [COL_W-1:0]  out_col_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [CHAN_W-1:0] red_q, green_q, blue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      out_valid_q <= s3_valid_q;
      out_col_q   <= s3_col_q;
      out_row_q   <= s3_row_q;
      red_q       <= s3_active_q ? CHAN_W'(pal.red)   : '0;
      green_q     <= s3_active_q ? CHAN_W'(pal.green) : '0;
      blue_q      <= s3_active_q ? CHAN_W'(pal.blue)  : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;

endmodule

// File: tb/tb_tilemap_pixel_pipe.sv
// Bench for tilemap_pixel_pipe: directed vector table, scroll/collision/reset sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_tilemap_pixel_pipe;
  import tilemap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid, pix_active, frame_start, map_we, scroll_we;
  logic [9:0]  pix_col;
  logic [8:0]  pix_row;
  logic [11:0] map_waddr;
  logic [7:0]  map_wdata;
  logic [8:0]  scroll_x_in, scroll_y_in;
  logic        out_valid;
  logic [9:0]  out_col;
  logic [8:0]  out_row;
  logic [3:0]  red, green, blue;

  always #5 clk = ~clk;

  tilemap_pixel_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_active (pix_active),
    .pix_col    (pix_col),
    .pix_row    (pix_row),
    .frame_start(frame_start),
    .map_we     (map_we),
    .map_waddr  (map_waddr),
    .map_wdata  (map_wdata),
    .scroll_we  (scroll_we),
    .scroll_x_in(scroll_x_in),
    .scroll_y_in(scroll_y_in),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] pal_ref [16];
  int unsigned map_m [4096];
  int unsigned sx_sh, sy_sh, sx_lv, sy_lv;

  typedef struct {
    bit          valid;
    bit          active;
    int unsigned col, row, mx, my;
  } pend_t;

  typedef struct {
    bit          valid;
    int unsigned col, row;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int unsigned col, row;
    bit          active;
    logic [11:0] rgb;
    string       name;
  } vec_t;

  pend_t pend;
  exp_t  exp_q[$];
  vec_t  vecs[7];

  function automatic logic [11:0] ref_colour(input int unsigned tile, input int unsigned px,
                                            input int unsigned py);
    int unsigned cidx;
    cidx = (3 * tile + px + py / 2) % 4;
    return pal_ref[(tile / 64) * 4 + cidx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    pend = '{valid: 1'b0, active: 1'b0, col: 0, row: 0, mx: 0, my: 0};
    exp_q.delete();
    sx_sh = 0; sy_sh = 0; sx_lv = 0; sy_lv = 0;
  endtask

  // One clock edge of the reference: resolve the pixel whose map lookup happens now (with the
  // map as it was before this edge's write), then accept the new pixel and scroll updates.
  task automatic model_edge();
    exp_t e;
    if (!rst_n) return;
    e.valid = pend.valid;
    e.col   = pend.col;
    e.row   = pend.row;
    e.rgb   = pend.active ?
              ref_colour(map_m[(pend.my / 8) * 64 + pend.mx / 8], pend.mx % 8, pend.my % 8) :
              12'h000;
    exp_q.push_back(e);
    if (map_we) map_m[map_waddr] = 32'(map_wdata);
    pend.valid  = pix_valid;
    pend.active = pix_active;
    pend.col    = 32'(pix_col);
    pend.row    = 32'(pix_row);
    pend.mx     = (32'(pix_col) + sx_lv) % 512;
    pend.my     = (32'(pix_row) + sy_lv) % 512;
    if (scroll_we) begin
      sx_sh = 32'(scroll_x_in);
      sy_sh = 32'(scroll_y_in);
    end
    if (frame_start) begin
      sx_lv = sx_sh;
      sy_lv = sy_sh;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (!rst_n) begin
      chk("reset_valid", 32'(out_valid), 32'h0);
      chk("reset_rgb", 32'({red, green, blue}), 32'h0);
      return;
    end
    e = '{valid: 1'b0, col: 0, row: 0, rgb: 12'h000};
    if (exp_q.size() > 2) e = exp_q.pop_front();
    chk("out_valid", 32'(out_valid), 32'(e.valid));
    if (e.valid) begin
      chk("pixel", {1'b0, out_col, out_row, red, green, blue},
          {1'b0, e.col[9:0], e.row[8:0], e.rgb});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0; pix_active = 1'b0; frame_start = 1'b0;
    map_we = 1'b0; scroll_we = 1'b0;
  endtask

  task automatic write_map(input int unsigned addr, input int unsigned data);
    map_we = 1'b1; map_waddr = 12'(addr); map_wdata = 8'(data);
    tick();
    map_we = 1'b0;
  endtask

  task automatic set_scroll(input int unsigned x, input int unsigned y, input bit fs);
    scroll_we = 1'b1; scroll_x_in = 9'(x); scroll_y_in = 9'(y); frame_start = fs;
    tick();
    scroll_we = 1'b0; frame_start = 1'b0;
  endtask

  // Single isolated pixel, result compared LATENCY edges later.
  task automatic probe(input string name, input int unsigned col, input int unsigned row,
                       input bit active, input logic [11:0] rgb);
    pix_valid = 1'b1; pix_col = 10'(col); pix_row = 9'(row); pix_active = active;
    tick();
    pix_valid = 1'b0;
    repeat (LATENCY - 1) tick();
    chk({name, "_valid"}, 32'(out_valid), 32'h1);
    chk(name, {1'b0, out_col, out_row, red, green, blue}, {1'b0, 10'(col), 9'(row), rgb});
  endtask

  initial begin
    pal_ref = '{12'h000, 12'h0F0, 12'h00F, 12'hF00, 12'h111, 12'h2A5, 12'h5C3, 12'hFF0,
                12'h888, 12'h0FF, 12'hF0F, 12'h7E1, 12'h123, 12'h456, 12'h9AB, 12'hFFF};
    vecs[0] = '{col: 0, row: 0,  active: 1'b1, rgb: 12'hF00, name: "zero_scroll_origin"};
    vecs[1] = '{col: 1, row: 0,  active: 1'b1, rgb: 12'h000, name: "tile1_px1"};
    vecs[2] = '{col: 8, row: 0,  active: 1'b1, rgb: 12'h5C3, name: "tile42_bank1"};
    vecs[3] = '{col: 3, row: 8,  active: 1'b1, rgb: 12'h123, name: "tileC7_bank3"};
    vecs[4] = '{col: 3, row: 13, active: 1'b1, rgb: 12'h9AB, name: "tileC7_py5"};
    vecs[5] = '{col: 0, row: 0,  active: 1'b0, rgb: 12'h000, name: "blanked"};
    vecs[6] = '{col: 9, row: 2,  active: 1'b1, rgb: 12'h111, name: "tile42_px1_py2"};

    idle_inputs();
    pix_col = '0; pix_row = '0; map_waddr = '0; map_wdata = '0;
    scroll_x_in = '0; scroll_y_in = '0;

    // Reset held with pixels offered: nothing may come out
    rst_n = 1'b0; pix_valid = 1'b1; pix_active = 1'b1;
    model_reset();
    repeat (3) tick();
    pix_valid = 1'b0; pix_active = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    // Blanked pixel so the colour is defined before the map is loaded
    pix_valid = 1'b1;
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      pix_valid = 1'b0;
      chk("first_valid_latency", 32'(out_valid), 32'(k == LATENCY));
    end

    for (int a = 0; a < 4096; a++) write_map(a, (a * 37 + 11) & 255);
    write_map(0, 1);
    write_map(1, 8'h42);
    write_map(64, 8'hC7);
    write_map(5, 8'h80);
    repeat (3) tick();

    foreach (vecs[i]) probe(vecs[i].name, vecs[i].col, vecs[i].row, vecs[i].active, vecs[i].rgb);

    // Scroll shadowing and wrap-around
    set_scroll(511, 0, 1'b0);
    probe("shadow_not_live", 1, 0, 1'b1, 12'h000);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    probe("x_wrap", 1, 0, 1'b1, 12'hF00);
    set_scroll(0, 0, 1'b0);
    probe("midframe_hold", 1, 0, 1'b1, 12'hF00);
    set_scroll(8, 0, 1'b1);
    probe("same_cycle_live", 0, 0, 1'b1, 12'h5C3);
    set_scroll(0, 8, 1'b1);
    probe("y_scroll", 3, 5, 1'b1, 12'h9AB);
    set_scroll(0, 0, 1'b1);

    // Map write colliding with a read of the same entry
    pix_valid = 1'b1; pix_active = 1'b1; pix_col = 10'd40; pix_row = 9'd0;
    tick();
    map_we = 1'b1; map_waddr = 12'd5; map_wdata = 8'd9;
    tick();
    map_we = 1'b0; pix_valid = 1'b0;
    repeat (2) tick();
    chk("collision_old", {out_valid, red, green, blue}, {1'b1, 12'h888});
    tick();
    chk("collision_new", {out_valid, red, green, blue}, {1'b1, 12'hF00});
    repeat (3) tick();

    // Randomized traffic with bubbles, blanking, map writes and scroll updates
    for (int n = 0; n < 3000; n++) begin
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_active  = ($urandom_range(0, 4) != 0);
      pix_col     = 10'($urandom_range(0, 1023));
      pix_row     = 9'($urandom_range(0, 511));
      map_we      = ($urandom_range(0, 9) == 0);
      map_waddr   = 12'($urandom_range(0, 4095));
      map_wdata   = 8'($urandom_range(0, 255));
      scroll_we   = ($urandom_range(0, 19) == 0);
      scroll_x_in = 9'($urandom_range(0, 511));
      scroll_y_in = 9'($urandom_range(0, 511));
      frame_start = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle_inputs();

    // Reset asserted mid-stream
    pix_valid = 1'b1; pix_active = 1'b1;
    for (int n = 0; n < 6; n++) begin
      pix_col = 10'($urandom_range(0, 1023));
      pix_row = 9'($urandom_range(0, 511));
      tick();
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_clear", 32'(out_valid), 32'h0);
    repeat (2) tick();
    pix_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    pix_valid = 1'b1;
    for (int k = 1; k <= LATENCY + 2; k++) begin
      pix_col = 10'($urandom_range(0, 1023));
      pix_row = 9'($urandom_range(0, 511));
      tick();
      if (k <= LATENCY) chk("post_reset_latency", 32'(out_valid), 32'(k == LATENCY));
    end
    idle_inputs();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
